tc0480scp_rom_server: RTL

//  Responder side of the toggle-style ROM request port driven by the TC0480SCP tile fetcher.

---
 rtl/tc0480scp_rom_server.sv | 122 ++++++++++++
 1 files changed

// File: rtl/tc0480scp_rom_server.sv
// rtl/tc0480scp_rom_server.sv - Toggle-handshake ROM responder with burst memory fetch and last-word cache
// Serves 64-bit words to the TC0480SCP tile fetcher; repeat fetches of the same word skip memory.
module tc0480scp_rom_server #(
  parameter int                ADDR_W    = 27,
  parameter int                DATA_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter bit                CACHE_EN  = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [22:0]       rom_address,
  input  logic              rom_req,
  output logic              rom_ack,
  output logic [63:0]       rom_data,
  input  logic              flush,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic              busy
);

  localparam int         BEATS = 64 / DATA_W;
  localparam logic [2:0] LAST  = 3'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, REQ, DATA, DONE} state_t;

  state_t            state;
  logic [19:0]       addr;
  logic [19:0]       tag;
  logic [63:0]       cache_data;
  logic [63:0]       fill;
  logic              valid;
  logic              flush_seen;
  logic [2:0]        beat;
  logic              pending;
  logic              hit;
  logic [ADDR_W-1:0] req_addr;
  logic              unused_low_bits;

  assign pending         = rom_req != rom_ack;
  assign hit             = CACHE_EN && valid && (tag == rom_address[22:3]) && !flush;
  assign req_addr        = BASE_ADDR + ADDR_W'({rom_address[22:3], 3'b000});
  assign unused_low_bits = ^rom_address[2:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rom_ack    <= 1'b0;
      rom_data   <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      busy       <= 1'b0;
      valid      <= 1'b0;
      tag        <= '0;
      cache_data <= '0;
      fill       <= '0;
      addr       <= '0;
      beat       <= '0;
      flush_seen <= 1'b0;
    end else begin
      if (flush) valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pending) begin
            addr <= rom_address[22:3];
            if (hit) begin
              rom_data <= cache_data;
              rom_ack  <= rom_req;
            end else begin
              state      <= REQ;
              mem_req    <= 1'b1;
              mem_addr   <= req_addr;
              busy       <= 1'b1;
              beat       <= '0;
              flush_seen <= 1'b0;
            end
          end
        end
        REQ: begin
          if (flush) flush_seen <= 1'b1;
          if (mem_gnt) begin
            mem_req <= 1'b0;
            // A beat arriving with the grant is beat 0.
            if (mem_rvalid) begin
              fill[DATA_W-1:0] <= mem_rdata;
              beat             <= 3'd1;
              state            <= (LAST == 3'd0) ? DONE : DATA;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (flush) flush_seen <= 1'b1;
          if (mem_rvalid) begin
            for (int k = 0; k < BEATS; k++) begin
              if (beat == 3'(k)) fill[k*DATA_W +: DATA_W] <= mem_rdata;
            end
            beat <= beat + 3'd1;
            if (beat == LAST) state <= DONE;
          end
        end
        DONE: begin
          rom_data <= fill;
          rom_ack  <= rom_req;
          busy     <= 1'b0;
          state    <= IDLE;
          if (CACHE_EN) begin
            tag        <= addr;
            cache_data <= fill;
            // A flush during the miss means the fetched word may already be stale.
            valid      <= !(flush_seen || flush);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
